inst_fetch_ctrl: RTL and testbench

Instruction-fetch stage controller for the myCPU pipeline. It issues requests on the SRAM-like instruction bus and tracks in-order responses, cancelling any that belong to a squashed path. Fetched instructions are buffered and handed to ID under the allow_in/valid_out handshake. It acts on the redirects that the hazard/flush logic and branch resolution produce, and drives the `if_ready_go`, `if_allow_in` and `data_ok_inst` status that the flush logic consumes.

---
 rtl/inst_fetch_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
//
// Instruction-fetch stage controller. It issues fetch requests on an SRAM-like
// instruction bus and tracks the in-order responses. Responses that belong to a
// squashed path are counted and dropped. Good responses are buffered and handed
// to ID through a valid/allow handshake.
//
// Ports
//   aclk, reset        clock and synchronous active-high reset
//   inst_req/addr      fetch request and address (address = fetch PC)
//   inst_addr_ok       request accepted this cycle
//   inst_data_ok/rdata one in-order response per pulse
//   redirect/_pc       squash the current path and restart at redirect_pc
//   id_allow_in        ID consumes the head entry this cycle
//   if_valid_out,
//   if_ready_go        head entry valid (both equal)
//   if_pc/if_inst      head PC and instruction (instruction is 0 for ADEF)
//   error_inst         head entry is a misaligned-PC (ADEF) entry
//   if_allow_in        a buffer credit is free (live + buf_count < BUF_DEPTH)
//   data_ok_inst       a non-cancelled response entered the buffer this cycle
//   cancel_busy        stale responses are still expected
// -----------------------------------------------------------------------------
module inst_fetch_ctrl #(
   parameter logic [31:0] RESET_PC        = 32'h1c000000,
   parameter int          MAX_OUTSTANDING = 2,   // 1..3
   parameter int          BUF_DEPTH       = 2    // 2..4
) (
   input  logic        aclk,
   input  logic        reset,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        id_allow_in,
   output logic        if_valid_out,
   output logic        if_ready_go,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        error_inst,
   output logic        if_allow_in,
   output logic        data_ok_inst,
   output logic        cancel_busy
);

   // Both queues use 2-bit ring pointers and 4-entry storage; only the first
   // MAX_OUTSTANDING / BUF_DEPTH slots are ever addressed.
   localparam logic [1:0] PCQ_LAST = 2'(MAX_OUTSTANDING - 1);
   localparam logic [1:0] BUF_LAST = 2'(BUF_DEPTH - 1);

   function automatic logic [1:0] pcq_inc(input logic [1:0] p);
      return (p == PCQ_LAST) ? 2'd0 : p + 2'd1;
   endfunction

   function automatic logic [1:0] buf_inc(input logic [1:0] p);
      return (p == BUF_LAST) ? 2'd0 : p + 2'd1;
   endfunction

   // ---------------------------------------------------------------- state
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [2:0]  total_q, total_d;        // in-flight requests incl. cancelled
   logic [2:0]  cancel_q, cancel_d;      // stale responses still to drop
   logic        halt_q, halt_d;          // set by an ADEF entry until redirect

   // PC queue holds only live requests; cancelled ones never touch it.
   logic [31:0] pcq_mem_q [4];
   logic [1:0]  pcq_wr_q, pcq_wr_d;
   logic [1:0]  pcq_rd_q, pcq_rd_d;

   logic [31:0] buf_pc_q   [4];
   logic [31:0] buf_inst_q [4];
   logic        buf_err_q  [4];
   logic [1:0]  buf_wr_q, buf_wr_d;
   logic [1:0]  buf_rd_q, buf_rd_d;
   logic [2:0]  buf_cnt_q, buf_cnt_d;

   // ------------------------------------------------------------ datapath
   logic [2:0]  live;
   logic [3:0]  occupancy;
   logic        credit;
   logic        accept;
   logic        dok_eff;
   logic        misalign_push;
   logic        head_valid;

   logic        pcq_push;
   logic        buf_push;
   logic        buf_pop;
   logic [31:0] buf_push_pc;
   logic [31:0] buf_push_inst;
   logic        buf_push_err;

   assign live      = total_q - cancel_q;
   assign occupancy = {1'b0, live} + {1'b0, buf_cnt_q};
   assign credit    = occupancy < 4'(BUF_DEPTH);
   assign head_valid = (buf_cnt_q != 3'd0);

   assign inst_req = !reset && !redirect && !halt_q && (fetch_pc_q[1:0] == 2'b00) &&
                     (total_q < 3'(MAX_OUTSTANDING)) && credit;
   assign inst_addr = reset ? RESET_PC : fetch_pc_q;
   assign accept    = inst_req && inst_addr_ok;

   // A response with nothing in flight is a stray pulse and is ignored.
   assign dok_eff = !reset && inst_data_ok && (total_q != 3'd0);

   // A misaligned PC is only reported once the bus has drained, so the ADEF
   // entry lands behind every instruction fetched before it.
   assign misalign_push = !reset && !redirect && !halt_q && (fetch_pc_q[1:0] != 2'b00) &&
                          (total_q == 3'd0) && credit;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      total_d       = total_q;
      cancel_d      = cancel_q;
      halt_d        = halt_q;
      pcq_wr_d      = pcq_wr_q;
      pcq_rd_d      = pcq_rd_q;
      buf_wr_d      = buf_wr_q;
      buf_rd_d      = buf_rd_q;
      buf_cnt_d     = buf_cnt_q;
      pcq_push      = 1'b0;
      buf_push      = 1'b0;
      buf_pop       = 1'b0;
      buf_push_pc   = 32'h0;
      buf_push_inst = 32'h0;
      buf_push_err  = 1'b0;

      if (redirect) begin
         // Everything still in flight becomes stale; a response arriving in
         // this very cycle is consumed and dropped here.
         fetch_pc_d = redirect_pc;
         halt_d     = 1'b0;
         total_d    = total_q - {2'b00, dok_eff};
         cancel_d   = total_q - {2'b00, dok_eff};
         pcq_wr_d   = 2'd0;
         pcq_rd_d   = 2'd0;
         buf_wr_d   = 2'd0;
         buf_rd_d   = 2'd0;
         buf_cnt_d  = 3'd0;
      end else begin
         if (dok_eff) begin
            if (cancel_q != 3'd0) begin
               cancel_d = cancel_q - 3'd1;
            end else begin
               buf_push      = 1'b1;
               buf_push_pc   = pcq_mem_q[pcq_rd_q];
               buf_push_inst = inst_rdata;
               pcq_rd_d      = pcq_inc(pcq_rd_q);
            end
         end

         if (accept) begin
            pcq_push   = 1'b1;
            pcq_wr_d   = pcq_inc(pcq_wr_q);
            fetch_pc_d = fetch_pc_q + 32'd4;
         end

         total_d = total_q + {2'b00, accept} - {2'b00, dok_eff};

         // total_q == 0 here, so this never collides with a response push.
         if (misalign_push) begin
            buf_push      = 1'b1;
            buf_push_pc   = fetch_pc_q;
            buf_push_inst = 32'h0;
            buf_push_err  = 1'b1;
            halt_d        = 1'b1;
         end

         buf_pop = head_valid && id_allow_in;

         if (buf_push) begin
            buf_wr_d = buf_inc(buf_wr_q);
         end
         if (buf_pop) begin
            buf_rd_d = buf_inc(buf_rd_q);
         end
         buf_cnt_d = buf_cnt_q + {2'b00, buf_push} - {2'b00, buf_pop};
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         total_q    <= 3'd0;
         cancel_q   <= 3'd0;
         halt_q     <= 1'b0;
         pcq_wr_q   <= 2'd0;
         pcq_rd_q   <= 2'd0;
         buf_wr_q   <= 2'd0;
         buf_rd_q   <= 2'd0;
         buf_cnt_q  <= 3'd0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         total_q    <= total_d;
         cancel_q   <= cancel_d;
         halt_q     <= halt_d;
         pcq_wr_q   <= pcq_wr_d;
         pcq_rd_q   <= pcq_rd_d;
         buf_wr_q   <= buf_wr_d;
         buf_rd_q   <= buf_rd_d;
         buf_cnt_q  <= buf_cnt_d;
      end
   end

   // Storage arrays carry no reset; the pointers define what is valid.
   always_ff @(posedge aclk) begin
      if (pcq_push) begin
         pcq_mem_q[pcq_wr_q] <= fetch_pc_q;
      end
      if (buf_push) begin
         buf_pc_q[buf_wr_q]   <= buf_push_pc;
         buf_inst_q[buf_wr_q] <= buf_push_inst;
         buf_err_q[buf_wr_q]  <= buf_push_err;
      end
   end

   // -------------------------------------------------------------- outputs
   assign if_valid_out = !reset && head_valid;
   assign if_ready_go  = if_valid_out;
   assign if_pc        = if_valid_out ? buf_pc_q[buf_rd_q] : 32'h0;
   assign if_inst      = if_valid_out ? buf_inst_q[buf_rd_q] : 32'h0;
   assign error_inst   = if_valid_out && buf_err_q[buf_rd_q];
   assign if_allow_in  = !reset && credit;
   assign data_ok_inst = !redirect && dok_eff && (cancel_q == 3'd0);
   assign cancel_busy  = !reset && (cancel_q != 3'd0);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl
//
// Cycle-by-cycle directed vectors for inst_fetch_ctrl: each record holds the
// inputs applied during one clock cycle and the outputs expected in that same
// cycle. A closing hand-written sequence streams four fetches through a
// 1-cycle responder and checks PC order and data.
// -----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

   logic        aclk = 1'b0;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_allow_in;
   logic        if_valid_out;
   logic        if_ready_go;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        error_inst;
   logic        if_allow_in;
   logic        data_ok_inst;
   logic        cancel_busy;

   always #5 aclk = ~aclk;

   inst_fetch_ctrl #(
      .RESET_PC        (32'h1c000000),
      .MAX_OUTSTANDING (2),
      .BUF_DEPTH       (2)
   ) dut (
      .aclk         (aclk),
      .reset        (reset),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .id_allow_in  (id_allow_in),
      .if_valid_out (if_valid_out),
      .if_ready_go  (if_ready_go),
      .if_pc        (if_pc),
      .if_inst      (if_inst),
      .error_inst   (error_inst),
      .if_allow_in  (if_allow_in),
      .data_ok_inst (data_ok_inst),
      .cancel_busy  (cancel_busy)
   );

   typedef struct {
      logic        rst;
      logic        aok;
      logic        dok;
      logic [31:0] rdata;
      logic        redir;
      logic [31:0] rpc;
      logic        allow;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_vld;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic        e_err;
      logic        e_ain;
      logic        e_dki;
      logic        e_cb;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   localparam logic [31:0] K = 32'h5a5a0000;

   task automatic add(input logic rst, input logic aok, input logic dok, input logic [31:0] rdata,
                      input logic redir, input logic [31:0] rpc, input logic allow,
                      input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                      input logic [31:0] e_pc, input logic [31:0] e_inst, input logic e_err,
                      input logic e_ain, input logic e_dki, input logic e_cb);
      vec_t v;
      v.rst = rst; v.aok = aok; v.dok = dok; v.rdata = rdata;
      v.redir = redir; v.rpc = rpc; v.allow = allow;
      v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
      v.e_inst = e_inst; v.e_err = e_err; v.e_ain = e_ain; v.e_dki = e_dki; v.e_cb = e_cb;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL vec %0d %s: got %h expected %h", row, name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic        prev_acc;
      logic [31:0] prev_addr;
      logic [31:0] exp_pc;
      int          got;

      reset = 1'b1; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
      redirect = 1'b0; redirect_pc = 32'h0; id_allow_in = 1'b0;

      //  rst aok dok rdata         rdr rpc           alw | req addr          vld pc            inst          err ain dki cb
      // reset
      add(1, 0, 0, 32'h0,        0, 32'h0,        0,   0, 32'h1c000000, 0, 32'h0,        32'h0,        0, 0, 0, 0);
      add(1, 0, 0, 32'h0,        0, 32'h0,        0,   0, 32'h1c000000, 0, 32'h0,        32'h0,        0, 0, 0, 0);
      // streaming with 1-cycle data return
      add(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h1c000000, 0, 32'h0,        32'h0,        0, 1, 0, 0);
      add(0, 1, 1, 32'hd0000000, 0, 32'h0,        1,   1, 32'h1c000004, 0, 32'h0,        32'h0,        0, 1, 1, 0);
      add(0, 1, 1, 32'hd0000001, 0, 32'h0,        1,   0, 32'h1c000008, 1, 32'h1c000000, 32'hd0000000, 0, 0, 1, 0);
      add(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h1c000008, 1, 32'h1c000004, 32'hd0000001, 0, 1, 0, 0);
      add(0, 1, 1, 32'hd0000002, 0, 32'h0,        1,   1, 32'h1c00000c, 0, 32'h0,        32'h0,        0, 1, 1, 0);
      add(0, 1, 1, 32'hd0000003, 0, 32'h0,        1,   0, 32'h1c000010, 1, 32'h1c000008, 32'hd0000002, 0, 0, 1, 0);
      // ID stalls: buffer fills, fetch stops
      add(0, 1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h1c000010, 1, 32'h1c00000c, 32'hd0000003, 0, 1, 0, 0);
      add(0, 1, 1, 32'hd0000004, 0, 32'h0,        0,   0, 32'h1c000014, 1, 32'h1c00000c, 32'hd0000003, 0, 0, 1, 0);
      add(0, 1, 0, 32'h0,        0, 32'h0,        0,   0, 32'h1c000014, 1, 32'h1c00000c, 32'hd0000003, 0, 0, 0, 0);
      add(0, 1, 0, 32'h0,        0, 32'h0,        0,   0, 32'h1c000014, 1, 32'h1c00000c, 32'hd0000003, 0, 0, 0, 0);
      // release: resume with no skipped PC
      add(0, 1, 0, 32'h0,        0, 32'h0,        1,   0, 32'h1c000014, 1, 32'h1c00000c, 32'hd0000003, 0, 0, 0, 0);
      add(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h1c000014, 1, 32'h1c000010, 32'hd0000004, 0, 1, 0, 0);
      add(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h1c000018, 0, 32'h0,        32'h0,        0, 1, 0, 0);
      // two outstanding, redirect to 1c000100; both responses stale
      add(0, 0, 0, 32'h0,        1, 32'h1c000100, 1,   0, 32'h1c00001c, 0, 32'h0,        32'h0,        0, 0, 0, 0);
      add(0, 0, 1, 32'hd0000005, 0, 32'h0,        1,   0, 32'h1c000100, 0, 32'h0,        32'h0,        0, 1, 0, 1);
      add(0, 1, 1, 32'hd0000006, 0, 32'h0,        1,   1, 32'h1c000100, 0, 32'h0,        32'h0,        0, 1, 0, 1);
      add(0, 0, 1, 32'hd0000007, 0, 32'h0,        1,   1, 32'h1c000104, 0, 32'h0,        32'h0,        0, 1, 1, 0);
      add(0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h1c000104, 1, 32'h1c000100, 32'hd0000007, 0, 1, 0, 0);
      // redirect coinciding with data_ok at total=2
      add(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h1c000104, 0, 32'h0,        32'h0,        0, 1, 0, 0);
      add(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h1c000108, 0, 32'h0,        32'h0,        0, 1, 0, 0);
      add(0, 0, 1, 32'hd0000008, 1, 32'h1c000200, 1,   0, 32'h1c00010c, 0, 32'h0,        32'h0,        0, 0, 0, 0);
      add(0, 0, 1, 32'hd0000009, 0, 32'h0,        1,   1, 32'h1c000200, 0, 32'h0,        32'h0,        0, 1, 0, 1);
      add(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h1c000200, 0, 32'h0,        32'h0,        0, 1, 0, 0);
      add(0, 0, 1, 32'hd000000a, 0, 32'h0,        1,   1, 32'h1c000204, 0, 32'h0,        32'h0,        0, 1, 1, 0);
      add(0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h1c000204, 1, 32'h1c000200, 32'hd000000a, 0, 1, 0, 0);
      // misaligned redirect -> ADEF entry, halt until next redirect
      add(0, 0, 0, 32'h0,        1, 32'h1c000102, 0,   0, 32'h1c000204, 0, 32'h0,        32'h0,        0, 1, 0, 0);
      add(0, 1, 0, 32'h0,        0, 32'h0,        0,   0, 32'h1c000102, 0, 32'h0,        32'h0,        0, 1, 0, 0);
      add(0, 1, 0, 32'h0,        0, 32'h0,        0,   0, 32'h1c000102, 1, 32'h1c000102, 32'h0,        1, 1, 0, 0);
      add(0, 1, 0, 32'h0,        0, 32'h0,        1,   0, 32'h1c000102, 1, 32'h1c000102, 32'h0,        1, 1, 0, 0);
      add(0, 1, 0, 32'h0,        0, 32'h0,        1,   0, 32'h1c000102, 0, 32'h0,        32'h0,        0, 1, 0, 0);
      add(0, 1, 0, 32'h0,        0, 32'h0,        1,   0, 32'h1c000102, 0, 32'h0,        32'h0,        0, 1, 0, 0);
      add(0, 0, 0, 32'h0,        1, 32'h1c000200, 1,   0, 32'h1c000102, 0, 32'h0,        32'h0,        0, 1, 0, 0);
      add(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h1c000200, 0, 32'h0,        32'h0,        0, 1, 0, 0);
      // one in flight, redirect -> cancel_cnt=1, then reset during cancellation
      add(0, 0, 0, 32'h0,        1, 32'h1c000300, 1,   0, 32'h1c000204, 0, 32'h0,        32'h0,        0, 1, 0, 0);
      add(0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h1c000300, 0, 32'h0,        32'h0,        0, 1, 0, 1);
      add(1, 0, 0, 32'h0,        0, 32'h0,        1,   0, 32'h1c000000, 0, 32'h0,        32'h0,        0, 0, 0, 0);
      add(0, 0, 1, 32'hd000000b, 0, 32'h0,        1,   1, 32'h1c000000, 0, 32'h0,        32'h0,        0, 1, 0, 0);
      add(0, 1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h1c000000, 0, 32'h0,        32'h0,        0, 1, 0, 0);
      add(0, 0, 1, 32'hd000000c, 0, 32'h0,        1,   1, 32'h1c000004, 0, 32'h0,        32'h0,        0, 1, 1, 0);
      add(0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h1c000004, 1, 32'h1c000000, 32'hd000000c, 0, 1, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge aclk);
         reset        = vecs[i].rst;
         inst_addr_ok = vecs[i].aok;
         inst_data_ok = vecs[i].dok;
         inst_rdata   = vecs[i].rdata;
         redirect     = vecs[i].redir;
         redirect_pc  = vecs[i].rpc;
         id_allow_in  = vecs[i].allow;
         #2;
         chk("inst_req",     i, {31'h0, inst_req},     {31'h0, vecs[i].e_req});
         chk("inst_addr",    i, inst_addr,             vecs[i].e_addr);
         chk("if_valid_out", i, {31'h0, if_valid_out}, {31'h0, vecs[i].e_vld});
         chk("if_ready_go",  i, {31'h0, if_ready_go},  {31'h0, vecs[i].e_vld});
         chk("error_inst",   i, {31'h0, error_inst},   {31'h0, vecs[i].e_err});
         chk("if_allow_in",  i, {31'h0, if_allow_in},  {31'h0, vecs[i].e_ain});
         chk("data_ok_inst", i, {31'h0, data_ok_inst}, {31'h0, vecs[i].e_dki});
         chk("cancel_busy",  i, {31'h0, cancel_busy},  {31'h0, vecs[i].e_cb});
         if (vecs[i].e_vld) begin
            chk("if_pc",   i, if_pc,   vecs[i].e_pc);
            chk("if_inst", i, if_inst, vecs[i].e_inst);
         end
         $display("vec %0d: req=%0b addr=%h vld=%0b pc=%h inst=%h err=%0b ain=%0b dok_inst=%0b cbusy=%0b",
                  i, inst_req, inst_addr, if_valid_out, if_pc, if_inst, error_inst,
                  if_allow_in, data_ok_inst, cancel_busy);
      end

      // Streaming with a responder that answers one cycle after acceptance.
      // Fetch resumes from 1c000004; data is address ^ K.
      prev_acc  = 1'b0;
      prev_addr = 32'h0;
      exp_pc    = 32'h1c000004;
      got       = 0;
      for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
         @(negedge aclk);
         reset        = 1'b0;
         redirect     = 1'b0;
         redirect_pc  = 32'h0;
         inst_addr_ok = 1'b1;
         id_allow_in  = 1'b1;
         inst_data_ok = prev_acc;
         inst_rdata   = prev_addr ^ K;
         #2;
         if (if_valid_out) begin
            chk("stream_pc",   got, if_pc,   exp_pc);
            chk("stream_inst", got, if_inst, exp_pc ^ K);
            $display("stream %0d: pc=%h inst=%h", got, if_pc, if_inst);
            exp_pc = exp_pc + 32'd4;
            got++;
         end
         prev_acc  = inst_req && inst_addr_ok;
         prev_addr = inst_addr;
      end
      checks++;
      if (got != 4) begin
         failures++;
         $display("FAIL stream_count: got %0d entries expected 4", got);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
